// File: rtl/eth_rx_fcs_check_pkg.sv
// eth_rx_pkg: shared types and constants for the receive-side Ethernet
// frame checker.
//   rx_state_e    : frame checker FSM states
//   ETH_PREAMBLE  : preamble byte (0x55)
//   ETH_SFD       : start-of-frame delimiter byte (0xD5)
//   ETH_FCS_BYTES : FCS length in bytes, also the depth of the delay line
//   FRAME_LEN_W   : width of the reported payload length
//   crc32_update  : one byte step of the reflected Ethernet CRC-32
package eth_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam int          ETH_FCS_BYTES = 4;
  localparam int          FRAME_LEN_W   = 11;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;

  // Bytes enter LSB first, so the bit-reversed polynomial is shifted right.
  function automatic logic [31:0] crc32_update(input logic [31:0] crc,
                                               input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_fcs_check_if.sv
// eth_rx_fcs_check_if: byte stream from the PHY receiver plus the payload
// stream and per-frame status presented to the packet parser.
//   rx_dv, rx_er, rx_data    : PHY byte stream (frame envelope, error, byte)
//   out_valid/out_sof/out_data : payload bytes with the FCS stripped
//   frame_done + status      : one-cycle strobe with frame_ok, fcs_err,
//                              len_err, phy_err and frame_len
//   bad_count                : saturating count of bad frames
// modport master: the side feeding the PHY bytes and consuming results.
// modport slave : the frame checker itself.
interface eth_rx_fcs_check_if;
  import eth_rx_pkg::*;

  logic                   rx_dv;
  logic                   rx_er;
  logic [7:0]             rx_data;
  logic                   out_valid;
  logic                   out_sof;
  logic [7:0]             out_data;
  logic                   frame_done;
  logic                   frame_ok;
  logic                   fcs_err;
  logic                   len_err;
  logic                   phy_err;
  logic [FRAME_LEN_W-1:0] frame_len;
  logic [15:0]            bad_count;

  modport master (
    output rx_dv, rx_er, rx_data,
    input  out_valid, out_sof, out_data, frame_done, frame_ok,
           fcs_err, len_err, phy_err, frame_len, bad_count
  );

  modport slave (
    input  rx_dv, rx_er, rx_data,
    output out_valid, out_sof, out_data, frame_done, frame_ok,
           fcs_err, len_err, phy_err, frame_len, bad_count
  );

endinterface

// File: rtl/eth_rx_fcs_check_crc32.sv
// crc32: running Ethernet CRC-32 over a byte stream.
//   clock, reset_n : byte clock, asynchronous active-low reset
//   clear          : 1 = restart (register preset to all ones)
//   data           : byte folded in on each cycle with clear = 0
//   result         : complemented CRC including the current data byte,
//                    byte k of result is FCS byte k on the wire
module crc32
  import eth_rx_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [7:0]  data,
  output logic [31:0] result
);

  logic [31:0] crc_q;
  logic [31:0] crc_next;

  assign crc_next = crc32_update(crc_q, data);
  assign result   = ~crc_next;

  // Running remainder; preset while cleared so the next frame starts fresh.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (clear) begin
      crc_q <= 32'hFFFFFFFF;
    end else begin
      crc_q <= crc_next;
    end
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: strips preamble/SFD, forwards payload with the FCS
// removed, checks FCS and length, and issues one status strobe per frame.
//   clock, reset_n : byte clock, asynchronous active-low reset
//   bus (slave)    : PHY byte input, payload output, frame status
//   MIN_LEN/MAX_LEN: legal frame length range in bytes, FCS included
// Optional: define FCS_CHECK_ERR_COUNT_EN to build the saturating bad-frame
// counter on bus.bad_count; otherwise bad_count is tied to zero.
module eth_rx_fcs_check
  import eth_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input logic               clock,
  input logic               reset_n,
  eth_rx_fcs_check_if.slave bus
);

  localparam logic [FRAME_LEN_W-1:0] FWD_LIMIT   = FRAME_LEN_W'(MAX_LEN - ETH_FCS_BYTES);
  localparam logic [FRAME_LEN_W-1:0] MIN_PAYLOAD = FRAME_LEN_W'(MIN_LEN - ETH_FCS_BYTES);
  localparam logic [FRAME_LEN_W-1:0] LEN_SAT     = '1;
  localparam logic [2:0]             FILL_FULL   = 3'(ETH_FCS_BYTES);

  rx_state_e              state_q, state_d;
  logic                   after_reset_q;
  logic                   seen_pre_q;
  logic [7:0]             d0_q, d1_q, d2_q, d3_q;
  logic [2:0]             fill_q;
  logic [FRAME_LEN_W-1:0] len_q;
  logic                   match_q;
  logic                   phy_q;
  logic                   enter_data, end_frame, push, payload, fwd;
  logic                   fcs_bad, len_bad, frame_bad;
  logic                   crc_clear;
  logic [31:0]            crc_result;

  logic                   out_valid_q, out_sof_q, frame_done_q, frame_ok_q;
  logic                   fcs_err_q, len_err_q, phy_err_q;
  logic [7:0]             out_data_q;
  logic [FRAME_LEN_W-1:0] frame_len_q;

  // The oldest delay-line byte is payload only once four newer bytes exist,
  // so the last four bytes of every frame never reach the CRC or output.
  assign push      = (state_q == ST_DATA) && bus.rx_dv;
  assign end_frame = (state_q == ST_DATA) && !bus.rx_dv;
  assign payload   = push && (fill_q == FILL_FULL);
  assign fwd       = payload && (len_q < FWD_LIMIT);
  assign crc_clear = !payload;
  assign fcs_bad   = !match_q || (fill_q != FILL_FULL);
  assign len_bad   = (len_q < MIN_PAYLOAD) || (len_q > FWD_LIMIT);
  assign frame_bad = fcs_bad | len_bad | phy_q;

  crc32 u_crc32 (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .data    (d3_q),
    .result  (crc_result)
  );

  // Next-state logic. A frame already in flight when reset is released is
  // dropped whole rather than mis-parsed from its middle.
  always_comb begin
    state_d    = state_q;
    enter_data = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_dv) state_d = after_reset_q ? ST_DROP : ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (!bus.rx_dv) begin
          state_d = ST_IDLE;
        end else if (bus.rx_data == ETH_PREAMBLE) begin
          state_d = ST_PREAMBLE;
        end else if ((bus.rx_data == ETH_SFD) && seen_pre_q) begin
          state_d    = ST_DATA;
          enter_data = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!bus.rx_dv) state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (!bus.rx_dv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus a one-cycle marker for the first edge after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      after_reset_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      after_reset_q <= 1'b0;
    end
  end

  // Remembers whether a preamble byte has been seen, including the byte
  // that opened the envelope, so an SFD without preamble is rejected.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seen_pre_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      seen_pre_q <= bus.rx_dv && (bus.rx_data == ETH_PREAMBLE);
    end else if ((state_q == ST_PREAMBLE) && (bus.rx_data == ETH_PREAMBLE)) begin
      seen_pre_q <= 1'b1;
    end
  end

  // Delay line, fill/length counters and the FCS comparison. match_q is
  // refreshed on every payload byte; the last refresh compares the CRC of
  // the full payload against the four bytes that followed it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      fill_q  <= '0;
      len_q   <= '0;
      match_q <= 1'b0;
      phy_q   <= 1'b0;
    end else if (enter_data) begin
      fill_q  <= '0;
      len_q   <= '0;
      match_q <= 1'b0;
      phy_q   <= 1'b0;
    end else if (push) begin
      d0_q <= bus.rx_data;
      d1_q <= d0_q;
      d2_q <= d1_q;
      d3_q <= d2_q;
      if (fill_q != FILL_FULL) fill_q <= fill_q + 3'd1;
      if (bus.rx_er) phy_q <= 1'b1;
      if (payload) begin
        match_q <= (crc_result == {bus.rx_data, d0_q, d1_q, d2_q});
        if (len_q != LEN_SAT) len_q <= len_q + 1'b1;
      end
    end
  end

  // Registered payload stream and per-frame status strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      fcs_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      phy_err_q    <= 1'b0;
      frame_len_q  <= '0;
    end else begin
      out_valid_q  <= fwd;
      out_sof_q    <= fwd && (len_q == '0);
      frame_done_q <= end_frame;
      if (payload) out_data_q <= d3_q;
      if (end_frame) begin
        frame_ok_q  <= !frame_bad;
        fcs_err_q   <= fcs_bad;
        len_err_q   <= len_bad;
        phy_err_q   <= phy_q;
        frame_len_q <= len_q;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sof    = out_sof_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.fcs_err    = fcs_err_q;
  assign bus.len_err    = len_err_q;
  assign bus.phy_err    = phy_err_q;
  assign bus.frame_len  = frame_len_q;

`ifdef FCS_CHECK_ERR_COUNT_EN
  logic [15:0] bad_cnt_q;

  // Counts bad frames in step with the status strobe, sticking at all ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bad_cnt_q <= '0;
    end else if (end_frame && frame_bad && (bad_cnt_q != 16'hFFFF)) begin
      bad_cnt_q <= bad_cnt_q + 16'd1;
    end
  end

  assign bus.bad_count = bad_cnt_q;
`else
  assign bus.bad_count = '0;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb_eth_rx_fcs_check: directed frames into eth_rx_fcs_check. Expected
// payload bytes and frame status are queued when a frame is issued; a
// monitor on the falling edge pops and compares whenever the DUT presents
// out_valid or frame_done.
module tb_eth_rx_fcs_check;
  import eth_rx_pkg::*;

  typedef struct {
    int         id;
    logic       sof;
    logic [7:0] data;
  } exp_byte_t;

  typedef struct {
    int          id;
    logic        ok;
    logic        fcs;
    logic        len;
    logic        phy;
    logic [10:0] flen;
    logic [15:0] bad;
  } exp_stat_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  exp_byte_t   byte_q[$];
  exp_stat_t   stat_q[$];
  logic [7:0]  pay_q[$];
  logic [7:0]  tx_q[$];
  int          checks   = 0;
  int          errors   = 0;
  int          frame_id = 0;
  logic [15:0] exp_bad  = '0;
  exp_byte_t   mon_b;
  exp_stat_t   mon_s;

  always #5 clock = ~clock;

  eth_rx_fcs_check_if bus_if ();

  eth_rx_fcs_check #(
    .MIN_LEN (64),
    .MAX_LEN (1518)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // Bit-serial reference CRC-32 (reflected, preset ones, final complement).
  function automatic logic [31:0] crcModel(input logic [7:0] q[$]);
    logic [31:0] crc;
    logic        fb;
    crc = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ q[i][b];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    return ~crc;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Drives tx_q as one envelope, then holds rx_dv low for gap cycles.
  task automatic applyStimulus(input int er_idx, input int gap);
    foreach (tx_q[i]) begin
      @(posedge clock); #1;
      bus_if.rx_dv   = 1'b1;
      bus_if.rx_data = tx_q[i];
      bus_if.rx_er   = (i == er_idx);
    end
    @(posedge clock); #1;
    bus_if.rx_dv   = 1'b0;
    bus_if.rx_er   = 1'b0;
    bus_if.rx_data = 8'h00;
    repeat (gap - 1) @(posedge clock);
  endtask

  // Frames pay_q with preamble/SFD/FCS, queues expectations, sends it.
  task automatic sendFrame(input int flip_byte, input int er_pos, input int gap,
                           input bit use_fixed, input logic [31:0] fixed_fcs);
    logic [31:0] fcs;
    int          n;
    exp_byte_t   b;
    exp_stat_t   s;
    n   = pay_q.size();
    fcs = use_fixed ? fixed_fcs : crcModel(pay_q);
    tx_q = {};
    repeat (7) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    foreach (pay_q[i]) tx_q.push_back(pay_q[i]);
    for (int k = 0; k < 4; k++) begin
      tx_q.push_back(fcs[8*k +: 8] ^ ((k == flip_byte) ? 8'h01 : 8'h00));
    end
    frame_id++;
    for (int i = 0; i < n && i < 1514; i++) begin
      b.id   = frame_id;
      b.sof  = (i == 0);
      b.data = pay_q[i];
      byte_q.push_back(b);
    end
    s.id   = frame_id;
    s.fcs  = (flip_byte >= 0);
    s.len  = ((n + 4) < 64) || ((n + 4) > 1518);
    s.phy  = (er_pos >= 0);
    s.ok   = !(s.fcs | s.len | s.phy);
    s.flen = (n > 2047) ? 11'd2047 : 11'(n);
`ifdef FCS_CHECK_ERR_COUNT_EN
    if (!s.ok && exp_bad != 16'hFFFF) exp_bad++;
`endif
    s.bad = exp_bad;
    stat_q.push_back(s);
    applyStimulus((er_pos >= 0) ? er_pos + 8 : -1, gap);
  endtask

  task automatic waitDrain();
    int cyc;
    cyc = 0;
    while ((byte_q.size() != 0 || stat_q.size() != 0) && cyc < 500) begin
      @(posedge clock);
      cyc++;
    end
    checkOutput("drain_bytes", 32'(byte_q.size()), 32'd0);
    checkOutput("drain_status", 32'(stat_q.size()), 32'd0);
    byte_q = {};
    stat_q = {};
  endtask

  // Scoreboard monitor, sampling on the falling edge away from updates.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus_if.out_valid) begin
        if (byte_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: actual %0h required none", bus_if.out_data);
        end else begin
          mon_b = byte_q.pop_front();
          checkOutput($sformatf("f%0d_byte", mon_b.id),
                      {23'd0, bus_if.out_sof, bus_if.out_data},
                      {23'd0, mon_b.sof, mon_b.data});
        end
      end
      if (bus_if.frame_done) begin
        checkOutput("done_with_valid", 32'(bus_if.out_valid), 32'd0);
        if (stat_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame_done: actual 1 required 0");
        end else begin
          mon_s = stat_q.pop_front();
          checkOutput($sformatf("f%0d_frame_ok", mon_s.id), 32'(bus_if.frame_ok), 32'(mon_s.ok));
          checkOutput($sformatf("f%0d_fcs_err", mon_s.id), 32'(bus_if.fcs_err), 32'(mon_s.fcs));
          checkOutput($sformatf("f%0d_len_err", mon_s.id), 32'(bus_if.len_err), 32'(mon_s.len));
          checkOutput($sformatf("f%0d_phy_err", mon_s.id), 32'(bus_if.phy_err), 32'(mon_s.phy));
          checkOutput($sformatf("f%0d_frame_len", mon_s.id), 32'(bus_if.frame_len), 32'(mon_s.flen));
          checkOutput($sformatf("f%0d_bad_count", mon_s.id), 32'(bus_if.bad_count), 32'(mon_s.bad));
          checkOutput($sformatf("f%0d_bytes_left", mon_s.id),
                      32'(byte_q.size() != 0 && byte_q[0].id == mon_s.id), 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus_if.rx_dv   = 1'b0;
    bus_if.rx_er   = 1'b0;
    bus_if.rx_data = 8'h00;
    reset_n        = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    checkOutput("rst_out_sof", 32'(bus_if.out_sof), 32'd0);
    checkOutput("rst_out_data", 32'(bus_if.out_data), 32'd0);
    checkOutput("rst_frame_done", 32'(bus_if.frame_done), 32'd0);
    checkOutput("rst_frame_ok", 32'(bus_if.frame_ok), 32'd0);
    checkOutput("rst_fcs_err", 32'(bus_if.fcs_err), 32'd0);
    checkOutput("rst_len_err", 32'(bus_if.len_err), 32'd0);
    checkOutput("rst_phy_err", 32'(bus_if.phy_err), 32'd0);
    checkOutput("rst_frame_len", 32'(bus_if.frame_len), 32'd0);
    checkOutput("rst_bad_count", 32'(bus_if.bad_count), 32'd0);
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clock);

    $display("[TB] good 60-byte frame, back-to-back with FCS-corrupted copy");
    pay_q = {};
    repeat (60) pay_q.push_back(8'h00);
    sendFrame(-1, -1, 1, 1'b0, 32'h0);
    sendFrame(2, -1, 8, 1'b0, 32'h0);

    $display("[TB] short frame 123456789");
    pay_q = {};
    for (int i = 0; i < 9; i++) pay_q.push_back(8'(49 + i));
    sendFrame(-1, -1, 8, 1'b1, 32'hCBF43926);

    $display("[TB] bad preamble, then good frame");
    tx_q = {};
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h5D);
    tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 0; i < 12; i++) tx_q.push_back(8'(i + 1));
    applyStimulus(-1, 8);
    pay_q = {};
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i * 3 + 1));
    sendFrame(-1, -1, 8, 1'b0, 32'h0);

    $display("[TB] oversize 1600-byte frame");
    pay_q = {};
    for (int i = 0; i < 1596; i++) pay_q.push_back(8'(i * 7));
    sendFrame(-1, -1, 8, 1'b0, 32'h0);

    $display("[TB] rx_er during payload");
    pay_q = {};
    for (int i = 0; i < 60; i++) pay_q.push_back(8'(i + 3));
    sendFrame(-1, 10, 8, 1'b0, 32'h0);
    waitDrain();

    $display("[TB] reset mid-payload with rx_dv held");
    tx_q = {};
    repeat (7) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    foreach (tx_q[i]) begin
      @(posedge clock); #1;
      bus_if.rx_dv   = 1'b1;
      bus_if.rx_data = tx_q[i];
    end
    @(posedge clock); #1;
    bus_if.rx_data = 8'hAA;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
    checkOutput("midrst_frame_done", 32'(bus_if.frame_done), 32'd0);
    checkOutput("midrst_frame_len", 32'(bus_if.frame_len), 32'd0);
    checkOutput("midrst_bad_count", 32'(bus_if.bad_count), 32'd0);
    exp_bad = '0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    tx_q = {};
    repeat (7) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    repeat (68) tx_q.push_back(8'h00);
    applyStimulus(-1, 8);

    $display("[TB] good frame after reset");
    pay_q = {};
    repeat (60) pay_q.push_back(8'hC3);
    sendFrame(-1, -1, 8, 1'b0, 32'h0);
    waitDrain();
    repeat (5) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
